// File: rtl/hilo_muldiv_sched.sv
// HI/LO owner and sequencer for the shared multiplier (MLU) and iterative divider.
// Raises stall_req while an operation is outstanding and forwards HI/LO to ID.
module hilo_muldiv_sched #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        ex_hold,
  input  logic        cancel,
  output logic        mul_start,
  output logic        mul_sign,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_sign,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       hi, lo, pend_hi, pend_lo;
  logic              first;
  logic              mul_sign_r, div_sign_r;
  logic              is_mul, is_div, div_zero;

  assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div   = (op == OP_DIV)  || (op == OP_DIVU);
  assign div_zero = (op2 == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cancel) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (is_mul)      state_nx = MUL;
              else if (is_div) state_nx = div_zero ? DONE : DIV;
        MUL:  if (cnt == '0)   state_nx = DONE;
        DIV:  if (div_ready)   state_nx = DONE;
        DONE: if (!ex_hold)    state_nx = IDLE;
        default:               state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    mul_start = 1'b0;
    div_start = 1'b0;
    stall_req = 1'b0;
    mul_sign  = mul_sign_r;
    div_sign  = div_sign_r;
    hi_o      = hi;
    lo_o      = lo;
    div_annul = !rst && cancel && (state == DIV);
    if (!rst && !cancel) begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            mul_start = 1'b1;
            mul_sign  = (op == OP_MULT);
            stall_req = 1'b1;
          end
          if (is_div) begin
            stall_req = 1'b1;
            if (!div_zero) begin
              div_start = 1'b1;
              div_sign  = (op == OP_DIV);
            end
          end
          if (op == OP_MTHI) hi_o = op1;
          if (op == OP_MTLO) lo_o = op1;
        end
        MUL, DIV: stall_req = 1'b1;
        DONE: if (first) begin
          hi_o = pend_hi;
          lo_o = pend_lo;
        end
        default: ;
      endcase
    end
  end

  // first marks the single DONE cycle that commits pending to HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi         <= '0;
      lo         <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      cnt        <= '0;
      first      <= 1'b0;
      mul_sign_r <= 1'b0;
      div_sign_r <= 1'b0;
    end else begin
      first <= (state_nx == DONE) && (state != DONE);
      if (cancel) begin
        pend_hi <= '0;
        pend_lo <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (op == OP_MTHI) hi <= op1;
            if (op == OP_MTLO) lo <= op1;
            if (is_mul) begin
              cnt        <= CNT_W'(MUL_LAT - 1);
              mul_sign_r <= (op == OP_MULT);
            end
            if (is_div) begin
              if (div_zero) begin
                pend_hi <= op1;
                pend_lo <= '1;
              end else begin
                div_sign_r <= (op == OP_DIV);
              end
            end
          end
          MUL: begin
            if (cnt == '0) {pend_hi, pend_lo} <= mul_result;
            else           cnt <= cnt - 1'b1;
          end
          DIV: if (div_ready) {pend_hi, pend_lo} <= div_result;
          DONE: if (first) begin
            hi <= pend_hi;
            lo <= pend_lo;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sched.sv
// Directed bench for hilo_muldiv_sched with small MLU and divider peripheral models.
module tb_hilo_muldiv_sched;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        ex_hold = 1'b0, cancel = 1'b0;
  logic        mul_start, mul_sign, div_start, div_sign, div_annul, div_ready, stall_req;
  logic [63:0] mul_result, div_result;
  logic [31:0] hi_o, lo_o;

  hilo_muldiv_sched #(.MUL_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .op1(op1), .op2(op2), .ex_hold(ex_hold),
    .cancel(cancel), .mul_start(mul_start), .mul_sign(mul_sign),
    .mul_result(mul_result), .div_start(div_start), .div_sign(div_sign),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .stall_req(stall_req), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // MLU model: product valid exactly LAT cycles after mul_start, garbage otherwise
  logic [3:0]  mcnt;
  logic [31:0] ma, mb;
  logic        ms;
  logic [63:0] prod;
  always @(posedge clk) begin
    if (rst) mcnt <= '0;
    else if (mul_start) begin
      mcnt <= 4'(LAT); ma <= op1; mb <= op2; ms <= mul_sign;
    end else if (mcnt != 0) mcnt <= mcnt - 4'd1;
  end
  always_comb begin
    if (ms) prod = {{32{ma[31]}}, ma} * {{32{mb[31]}}, mb};
    else    prod = {32'b0, ma} * {32'b0, mb};
    mul_result = (mcnt == 4'd1) ? prod : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // Divider model: ready pulse 33 cycles after div_start; ignores annul
  logic [5:0]  dcnt;
  logic [31:0] da, db, dq, dr;
  logic        ds;
  always @(posedge clk) begin
    if (rst) dcnt <= '0;
    else if (div_start) begin
      dcnt <= 6'd33; da <= op1; db <= op2; ds <= div_sign;
    end else if (dcnt != 0) dcnt <= dcnt - 6'd1;
  end
  assign div_ready = (dcnt == 6'd1);
  always_comb begin
    dq = '0;
    dr = '0;
    if (db != 0) begin
      if (ds) begin
        dq = $signed(da) / $signed(db);
        dr = $signed(da) % $signed(db);
      end else begin
        dq = da / db;
        dr = da % db;
      end
    end
    div_result = div_ready ? {dr, dq} : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  int unsigned n_mstart = 0, n_dstart = 0, n_annul = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (mul_start) n_mstart <= n_mstart + 1;
      if (div_start) n_dstart <= n_dstart + 1;
      if (div_annul) n_annul  <= n_annul + 1;
    end
  end

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic h, input logic c);
    @(negedge clk);
    op = o; op1 = a; op2 = b; ex_hold = h; cancel = c;
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    int unsigned stalls, mst, dst;
  } vec_t;
  vec_t vt[11];

  initial begin
    int unsigned cyc, m0, d0, a0;

    vt[0]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,        32'h1,         32'hFFFF_FFFE, 3,  1, 0};
    vt[1]  = '{3'b001, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 3,  1, 0};
    vt[2]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         3,  1, 0};
    vt[3]  = '{3'b011, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0, 1};
    vt[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'h1,         32'h7FFF_FFFC, 34, 0, 1};
    vt[5]  = '{3'b011, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 34, 0, 1};
    vt[6]  = '{3'b100, 32'h1234,      32'd0,        32'h1234,      32'hFFFF_FFFF, 1,  0, 0};
    vt[7]  = '{3'b101, 32'hA5A5_0000, 32'd9,        32'hA5A5_0000, 32'hFFFF_FFFF, 0,  0, 0};
    vt[8]  = '{3'b110, 32'h5A5A,      32'd9,        32'hA5A5_0000, 32'h5A5A,      0,  0, 0};
    vt[9]  = '{3'b111, 32'hDEAD_BEEF, 32'd1,        32'hA5A5_0000, 32'h5A5A,      0,  0, 0};
    vt[10] = '{3'b000, 32'hCAFE_F00D, 32'd0,        32'hA5A5_0000, 32'h5A5A,      0,  0, 0};

    // reset state, including a mult presented while rst is high
    drive(3'b000, 0, 0, 0, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_signs", {mul_sign, div_sign, div_annul}, 0);
    drive(3'b001, 32'd3, 32'd4, 0, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_stall_op", stall_req, 0);
    @(negedge clk);
    rst = 1'b0; op = '0;

    for (int i = 0; i < 11; i++) begin
      m0 = n_mstart; d0 = n_dstart; cyc = 0;
      drive(vt[i].op, vt[i].a, vt[i].b, 0, 0);
      if (vt[i].op == 3'b001) chk($sformatf("v%0d_mul_sign", i), mul_sign, 1);
      if (vt[i].op == 3'b011) chk($sformatf("v%0d_div_sign", i), div_sign, vt[i].dst);
      while (stall_req && cyc < 200) begin
        cyc++;
        drive(vt[i].op, vt[i].a, vt[i].b, 0, 0);
      end
      chk($sformatf("v%0d_fwd_hi", i), hi_o, vt[i].ehi);
      chk($sformatf("v%0d_fwd_lo", i), lo_o, vt[i].elo);
      drive(3'b000, 0, 0, 0, 0);
      chk($sformatf("v%0d_reg_hi", i), hi_o, vt[i].ehi);
      chk($sformatf("v%0d_reg_lo", i), lo_o, vt[i].elo);
      chk($sformatf("v%0d_stalls", i), cyc, vt[i].stalls);
      chk($sformatf("v%0d_mstart", i), n_mstart - m0, vt[i].mst);
      chk($sformatf("v%0d_dstart", i), n_dstart - d0, vt[i].dst);
    end

    // back-to-back mthi / mtlo
    drive(3'b101, 32'h1111_0000, 0, 0, 0);
    chk("b2b_hi_fwd", hi_o, 32'h1111_0000);
    chk("b2b_stall0", stall_req, 0);
    drive(3'b110, 32'h2222, 0, 0, 0);
    chk("b2b_hi_reg", hi_o, 32'h1111_0000);
    chk("b2b_lo_fwd", lo_o, 32'h2222);
    chk("b2b_stall1", stall_req, 0);
    drive(3'b000, 0, 0, 0, 0);
    chk("b2b_lo_reg", lo_o, 32'h2222);

    // mult 3*5 finishing while EX is held for 3 cycles
    m0 = n_mstart;
    for (int c = 0; c < 3; c++) drive(3'b001, 32'd3, 32'd5, 0, 0);
    chk("hold_stall_busy", stall_req, 1);
    for (int c = 0; c < 3; c++) begin
      drive(3'b001, 32'd3, 32'd5, 1, 0);
      chk($sformatf("hold_stall_%0d", c), stall_req, 0);
      chk($sformatf("hold_hilo_%0d", c), {hi_o, lo_o}, 64'hF);
    end
    drive(3'b001, 32'd3, 32'd5, 0, 0);
    chk("hold_release_stall", stall_req, 0);
    drive(3'b101, 32'h77, 0, 0, 0);
    chk("hold_idle_fwd", hi_o, 32'h77);
    chk("hold_idle_stall", stall_req, 0);
    drive(3'b000, 0, 0, 0, 0);
    chk("hold_one_start", n_mstart - m0, 1);
    chk("hold_hilo_after", {hi_o, lo_o}, {32'h77, 32'hF});

    // divide cancelled at cycle 10; the later div_ready must be ignored
    a0 = n_annul;
    for (int c = 0; c < 10; c++) drive(3'b011, 32'd100, 32'd3, 0, 0);
    chk("cancel_busy", stall_req, 1);
    drive(3'b011, 32'd100, 32'd3, 0, 1);
    chk("cancel_annul", div_annul, 1);
    chk("cancel_stall", stall_req, 0);
    drive(3'b000, 0, 0, 0, 0);
    chk("cancel_annul_off", div_annul, 0);
    chk("cancel_stall_off", stall_req, 0);
    for (int c = 0; c < 30; c++) drive(3'b000, 0, 0, 0, 0);
    chk("cancel_hilo", {hi_o, lo_o}, {32'h77, 32'hF});
    chk("cancel_annul_cnt", n_annul - a0, 1);

    // cancel on the DONE write cycle suppresses the write
    for (int c = 0; c < 3; c++) drive(3'b010, 32'd2, 32'd3, 0, 0);
    drive(3'b010, 32'd2, 32'd3, 0, 1);
    drive(3'b000, 0, 0, 0, 0);
    chk("cancel_done_hilo", {hi_o, lo_o}, {32'h77, 32'hF});
    chk("cancel_done_stall", stall_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
